// File: rtl/vend_seq_ctrl.sv
// Vending sequencing controller: two-slot coin arbitration, dispense and change handshakes.
// Optional macro REFUND_EN enables cancel-driven full refund from IDLE.
module vend_seq_ctrl #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7,
    parameter int CRED_W     = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        coin_a,
    input  logic [1:0]        coin_b,
    input  logic              sel,
    input  logic              cancel,
    input  logic              disp_ack,
    input  logic              chg_ack,
    output logic              coin_rej_a,
    output logic              coin_rej_b,
    output logic              disp_req,
    output logic              chg_req,
    output logic [CRED_W-1:0] credit,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CRED_W:0]  PRICE_W  = (CRED_W + 1)'(PRICE);
    localparam logic [CRED_W:0]  MAX_W    = (CRED_W + 1)'(MAX_CREDIT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    function automatic logic [CRED_W:0] coin_val(input logic [1:0] c);
        case (c)
            2'b01:   coin_val = (CRED_W + 1)'(1);
            2'b10:   coin_val = (CRED_W + 1)'(2);
            default: coin_val = {(CRED_W + 1){1'b0}};
        endcase
    endfunction

    state_t             state_r;
    logic [CRED_W-1:0]  credit_r;
    logic               rr_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               coin_rej_a_r, coin_rej_b_r, disp_req_r, chg_req_r, busy_r, err_r;

    logic [CRED_W:0]    credit_ext_s, sum_a_s, sum_b_s, rem_s;
    logic               val_a_s, val_b_s, fit_a_s, fit_b_s, refund_s;

`ifdef REFUND_EN
    assign refund_s = cancel && (credit_r != {CRED_W{1'b0}});
`else
    logic unused_cancel_s;
    assign unused_cancel_s = cancel;
    assign refund_s        = 1'b0;
`endif

    // Widened credit arithmetic so the ceiling compare can never wrap
    always_comb begin
        credit_ext_s = {1'b0, credit_r};
        sum_a_s      = credit_ext_s + coin_val(coin_a);
        sum_b_s      = credit_ext_s + coin_val(coin_b);
        rem_s        = credit_ext_s - PRICE_W;
        val_a_s      = (coin_a == 2'b01) || (coin_a == 2'b10);
        val_b_s      = (coin_b == 2'b01) || (coin_b == 2'b10);
        fit_a_s      = (sum_a_s <= MAX_W);
        fit_b_s      = (sum_b_s <= MAX_W);
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            credit_r     <= {CRED_W{1'b0}};
            rr_r         <= 1'b0;
            tmo_r        <= {TMO_W{1'b0}};
            coin_rej_a_r <= 1'b0;
            coin_rej_b_r <= 1'b0;
            disp_req_r   <= 1'b0;
            chg_req_r    <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            coin_rej_a_r <= (coin_a != 2'b00);
            coin_rej_b_r <= (coin_b != 2'b00);
            case (state_r)
                IDLE: begin
                    if (refund_s) begin
                        state_r   <= CHANGE;
                        chg_req_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end else if (sel && (credit_ext_s >= PRICE_W)) begin
                        state_r    <= DISPENSE;
                        disp_req_r <= 1'b1;
                        tmo_r      <= {TMO_W{1'b0}};
                        busy_r     <= 1'b1;
                    end else if (val_a_s && val_b_s) begin
                        // Contention: rr slot is served, the other refused
                        rr_r <= ~rr_r;
                        if (!rr_r) begin
                            coin_rej_a_r <= !fit_a_s;
                            if (fit_a_s) credit_r <= sum_a_s[CRED_W-1:0];
                            else         credit_r <= credit_r;
                        end else begin
                            coin_rej_b_r <= !fit_b_s;
                            if (fit_b_s) credit_r <= sum_b_s[CRED_W-1:0];
                            else         credit_r <= credit_r;
                        end
                    end else if (val_a_s) begin
                        coin_rej_a_r <= !fit_a_s;
                        if (fit_a_s) credit_r <= sum_a_s[CRED_W-1:0];
                        else         credit_r <= credit_r;
                    end else if (val_b_s) begin
                        coin_rej_b_r <= !fit_b_s;
                        if (fit_b_s) credit_r <= sum_b_s[CRED_W-1:0];
                        else         credit_r <= credit_r;
                    end else begin
                        credit_r <= credit_r;
                    end
                end
                DISPENSE: begin
                    if (disp_ack && disp_req_r) begin
                        disp_req_r <= 1'b0;
                        credit_r   <= rem_s[CRED_W-1:0];
                        if (rem_s != {(CRED_W + 1){1'b0}}) begin
                            state_r   <= CHANGE;
                            chg_req_r <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        state_r    <= FAULT;
                        disp_req_r <= 1'b0;
                        err_r      <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + {{(TMO_W - 1){1'b0}}, 1'b1};
                    end
                end
                CHANGE: begin
                    if (credit_r == {CRED_W{1'b0}}) begin
                        state_r   <= IDLE;
                        chg_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else if (chg_ack && chg_req_r) begin
                        credit_r <= credit_r - {{(CRED_W - 1){1'b0}}, 1'b1};
                        if (credit_r == {{(CRED_W - 1){1'b0}}, 1'b1}) begin
                            state_r   <= IDLE;
                            chg_req_r <= 1'b0;
                            busy_r    <= 1'b0;
                        end else begin
                            chg_req_r <= 1'b1;
                        end
                    end else begin
                        chg_req_r <= 1'b1;
                    end
                end
                FAULT: begin
                    err_r  <= 1'b1;
                    busy_r <= 1'b1;
                end
                default: begin
                    state_r    <= FAULT;
                    disp_req_r <= 1'b0;
                    chg_req_r  <= 1'b0;
                    err_r      <= 1'b1;
                    busy_r     <= 1'b1;
                end
            endcase
        end
    end

    assign coin_rej_a = coin_rej_a_r;
    assign coin_rej_b = coin_rej_b_r;
    assign disp_req   = disp_req_r;
    assign chg_req    = chg_req_r;
    assign credit     = credit_r;
    assign busy       = busy_r;
    assign err        = err_r;
endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Directed self-checking bench for vend_seq_ctrl (default parameters).
module tb_vend_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] coin_a = 2'b00, coin_b = 2'b00;
    logic       sel = 1'b0, cancel = 1'b0, disp_ack = 1'b0, chg_ack = 1'b0;
    logic       coin_rej_a, coin_rej_b, disp_req, chg_req, busy, err;
    logic [2:0] credit;
    int         n_tests = 0;
    int         n_fail  = 0;

    vend_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .coin_a(coin_a), .coin_b(coin_b), .sel(sel),
        .cancel(cancel), .disp_ack(disp_ack), .chg_ack(chg_ack),
        .coin_rej_a(coin_rej_a), .coin_rej_b(coin_rej_b), .disp_req(disp_req),
        .chg_req(chg_req), .credit(credit), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // One clock edge with the current inputs, then clear them and settle at negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        coin_a = 2'b00; coin_b = 2'b00; sel = 1'b0; cancel = 1'b0;
        disp_ack = 1'b0; chg_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({coin_rej_a, coin_rej_b, disp_req, chg_req, credit, busy, err} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0", {coin_rej_a, coin_rej_b, disp_req, chg_req, credit, busy, err});
        end
    endtask

    task automatic test_exact_buy();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            coin_a = 2'b01; tick();
            chk("exact_credit", 8'(credit), 8'(i));
        end
        sel = 1'b1; tick();
        chk("exact_disp_req", 8'(disp_req), 8'd1);
        chk("exact_busy_disp", 8'(busy), 8'd1);
        disp_ack = 1'b1; tick();
        chk("exact_credit_after", 8'(credit), 8'd0);
        chk("exact_disp_drop", 8'(disp_req), 8'd0);
        chk("exact_busy_idle", 8'(busy), 8'd0);
        chk("exact_no_chg", 8'(chg_req), 8'd0);
        tick();
        chk("exact_no_chg_later", 8'(chg_req), 8'd0);
    endtask

    task automatic test_change();
        do_reset();
        coin_a = 2'b10; tick();
        coin_a = 2'b10; tick();
        chk("chg_credit4", 8'(credit), 8'd4);
        sel = 1'b1; coin_b = 2'b01; tick();
        chk("chg_sel_coin_rej", 8'(coin_rej_b), 8'd1);
        chk("chg_sel_credit", 8'(credit), 8'd4);
        disp_ack = 1'b1; tick();
        chk("chg_remainder", 8'(credit), 8'd1);
        chk("chg_req_on", 8'(chg_req), 8'd1);
        chk("chg_busy", 8'(busy), 8'd1);
        tick();
        chk("chg_req_held", 8'(chg_req), 8'd1);
        chg_ack = 1'b1; tick();
        chk("chg_credit0", 8'(credit), 8'd0);
        chk("chg_req_off", 8'(chg_req), 8'd0);
        chk("chg_idle", 8'(busy), 8'd0);
    endtask

    task automatic test_contention();
        do_reset();
        coin_a = 2'b10; coin_b = 2'b01; tick();
        chk("rr1_credit", 8'(credit), 8'd2);
        chk("rr1_rej_a", 8'(coin_rej_a), 8'd0);
        chk("rr1_rej_b", 8'(coin_rej_b), 8'd1);
        coin_a = 2'b10; coin_b = 2'b01; tick();
        chk("rr2_credit", 8'(credit), 8'd3);
        chk("rr2_rej_a", 8'(coin_rej_a), 8'd1);
        chk("rr2_rej_b", 8'(coin_rej_b), 8'd0);
        tick();
        chk("rr_pulse_end", 8'({coin_rej_a, coin_rej_b}), 8'd0);
        sel = 1'b1; tick();
        chk("rr_sel_disp", 8'(disp_req), 8'd1);
    endtask

    task automatic test_saturation();
        do_reset();
        sel = 1'b1; coin_a = 2'b01; tick();
        chk("sat_low_sel_ignored", 8'(busy), 8'd0);
        coin_a = 2'b10; tick();
        coin_a = 2'b10; tick();
        chk("sat_credit5", 8'(credit), 8'd5);
        coin_b = 2'b01; tick();
        chk("sat_credit6", 8'(credit), 8'd6);
        coin_b = 2'b10; tick();
        chk("sat_rej_b", 8'(coin_rej_b), 8'd1);
        chk("sat_credit_hold", 8'(credit), 8'd6);
        coin_a = 2'b11; tick();
        chk("sat_invalid_rej_a", 8'(coin_rej_a), 8'd1);
        chk("sat_invalid_credit", 8'(credit), 8'd6);
        coin_a = 2'b01; tick();
        chk("sat_reach_max", 8'(credit), 8'd7);
        chk("sat_max_no_rej", 8'(coin_rej_a), 8'd0);
        coin_a = 2'b01; tick();
        chk("sat_over_rej", 8'(coin_rej_a), 8'd1);
        chk("sat_over_credit", 8'(credit), 8'd7);
    endtask

    task automatic test_timeout();
        do_reset();
        coin_a = 2'b10; tick();
        coin_a = 2'b01; tick();
        sel = 1'b1; tick();
        repeat (14) tick();
        chk("tmo_err_before", 8'(err), 8'd0);
        chk("tmo_disp_before", 8'(disp_req), 8'd1);
        tick();
        chk("tmo_err", 8'(err), 8'd1);
        chk("tmo_busy", 8'(busy), 8'd1);
        chk("tmo_disp_off", 8'(disp_req), 8'd0);
        chk("tmo_credit", 8'(credit), 8'd3);
        coin_a = 2'b01; disp_ack = 1'b1; tick();
        chk("fault_coin_rej", 8'(coin_rej_a), 8'd1);
        chk("fault_credit", 8'(credit), 8'd3);
        chk("fault_sticky", 8'(err), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 8'({coin_rej_a, coin_rej_b, disp_req, chg_req, busy, err}), 8'd0);
        chk("async_reset_credit", 8'(credit), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_refund();
        do_reset();
        coin_a = 2'b10; tick();
        disp_ack = 1'b1; chg_ack = 1'b1; tick();
        chk("stray_ack_credit", 8'(credit), 8'd2);
        cancel = 1'b1; sel = 1'b1; tick();
`ifdef REFUND_EN
        chk("refund_chg_req", 8'(chg_req), 8'd1);
        chk("refund_busy", 8'(busy), 8'd1);
        chk("refund_no_disp", 8'(disp_req), 8'd0);
        chg_ack = 1'b1; tick();
        chk("refund_credit1", 8'(credit), 8'd1);
        chk("refund_req_held", 8'(chg_req), 8'd1);
        chg_ack = 1'b1; tick();
        chk("refund_credit0", 8'(credit), 8'd0);
        chk("refund_req_off", 8'(chg_req), 8'd0);
        chk("refund_idle", 8'(busy), 8'd0);
`else
        chk("norefund_credit", 8'(credit), 8'd2);
        chk("norefund_busy", 8'(busy), 8'd0);
        chk("norefund_chg_req", 8'(chg_req), 8'd0);
`endif
    endtask

    initial begin
        test_reset();
        test_exact_buy();
        test_change();
        test_contention();
        test_saturation();
        test_timeout();
        test_refund();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
